psdu_bit_source: RTL

// - Transmit-side bitstream source for the 802.11a TX front end. Drives the 1-bit

---
 rtl/tx_pkg.sv | 32 +++
 rtl/byte_to_bit_serializer.sv | 82 ++++++++
 rtl/psdu_bit_source.sv | 119 +++++++++++
 3 files changed

// File: rtl/tx_pkg.sv
// Shared constants, RATE codes and FSM state type for the 802.11a TX bit source.
package tx_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 12;

    typedef enum logic [3:0] {
        Rate6  = 4'b1101,
        Rate9  = 4'b1111,
        Rate12 = 4'b0101,
        Rate18 = 4'b0111,
        Rate24 = 4'b1001,
        Rate36 = 4'b1011,
        Rate48 = 4'b0001,
        Rate54 = 4'b0011
    } rate_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    function automatic logic is_legal_rate(input logic [3:0] code);
        case (code)
            Rate6, Rate9, Rate12, Rate18,
            Rate24, Rate36, Rate48, Rate54: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/byte_to_bit_serializer.sv
// One-byte holding register feeding an LSB-first shift register; streams one bit per
// handshake and refills from hold on the last bit so full throughput has no bubbles.
module byte_to_bit_serializer #(
    parameter int unsigned BYTE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_val,
    output logic              byte_rdy,
    output logic              bit_out,
    output logic              bit_val,
    input  logic              bit_rdy,
    output logic              last_bit
);

    localparam int unsigned CNT_W = $clog2(BYTE_W);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BYTE_W - 1);

    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              sh_valid_q, sh_valid_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;

    logic bit_hs;
    logic wr;
    logic load;

    assign bit_hs   = sh_valid_q && bit_rdy;
    assign wr       = byte_val && !hold_full_q;
    // Refill either into an empty shifter or on the final bit's handshake.
    assign load     = hold_full_q && (!sh_valid_q || (bit_hs && (bit_cnt_q == LastCnt)));

    assign byte_rdy = !hold_full_q;
    assign bit_out  = shreg_q[0];
    assign bit_val  = sh_valid_q;
    assign last_bit = sh_valid_q && (bit_cnt_q == LastCnt);

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        sh_valid_d  = sh_valid_q;
        bit_cnt_d   = bit_cnt_q;

        if (bit_hs) begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LastCnt) begin
                sh_valid_d = 1'b0;
            end
        end
        if (load) begin
            shreg_d     = hold_q;
            sh_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            hold_full_d = 1'b0;
        end
        if (wr) begin
            hold_d      = byte_in;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            sh_valid_q  <= 1'b0;
            bit_cnt_q   <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            sh_valid_q  <= sh_valid_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/psdu_bit_source.sv
// PSDU bitstream source: accepts a frame request, counts PSDU bytes in and streams
// them LSB-first to the TX chain, with frame_done/err status pulses.
module psdu_bit_source #(
    parameter int unsigned BYTE_W = 8,
    parameter int unsigned LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        rate,
    input  logic [LEN_W-1:0]  length,
    output logic              start_rdy,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_val,
    output logic              byte_rdy,
    output logic              data_out,
    output logic              ostream_val,
    input  logic              ostream_rdy,
    output logic [3:0]        rate_out,
    output logic [LEN_W-1:0]  length_out,
    output logic              frame_active,
    output logic              frame_done,
    output logic              err
);

    import tx_pkg::*;

    state_e           state_q, state_d;
    logic [3:0]       rate_q, rate_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic [LEN_W-1:0] bytes_acc_q, bytes_acc_d;
    logic             err_q, err_d;

    logic run;
    logic room;
    logic ser_byte_rdy;
    logic ser_byte_val;
    logic ser_last_bit;
    logic frame_end;

    assign run          = (state_q == StRun);
    assign room         = (bytes_acc_q < length_q);
    assign byte_rdy     = run && ser_byte_rdy && room;
    assign ser_byte_val = byte_val && byte_rdy;
    // Last bit of the last byte: everything accepted and nothing left waiting in hold.
    assign frame_end    = run && ostream_val && ostream_rdy && ser_last_bit
                          && ser_byte_rdy && !room;

    byte_to_bit_serializer #(
        .BYTE_W (BYTE_W)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .byte_in  (byte_in),
        .byte_val (ser_byte_val),
        .byte_rdy (ser_byte_rdy),
        .bit_out  (data_out),
        .bit_val  (ostream_val),
        .bit_rdy  (ostream_rdy),
        .last_bit (ser_last_bit)
    );

    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        length_d    = length_q;
        bytes_acc_d = bytes_acc_q;
        err_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_legal_rate(rate) && (length != '0)) begin
                        rate_d      = rate;
                        length_d    = length;
                        bytes_acc_d = '0;
                        state_d     = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (ser_byte_val) begin
                    bytes_acc_d = bytes_acc_q + LEN_W'(1);
                end
                if (frame_end) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            rate_q      <= '0;
            length_q    <= '0;
            bytes_acc_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            length_q    <= length_d;
            bytes_acc_q <= bytes_acc_d;
            err_q       <= err_d;
        end
    end

    assign start_rdy    = (state_q == StIdle);
    assign frame_active = run;
    assign frame_done   = (state_q == StDone);
    assign err          = err_q;
    assign rate_out     = rate_q;
    assign length_out   = length_q;

endmodule
